mem_master: RTL

//  Initiator side of the 16-bit synchronous RAM port. Accepts CPU load/store requests (byte or word, byte-addressed)

---
 rtl/mem_master_pkg.sv | 30 +++
 rtl/mem_master_byte_lane.sv | 33 +++
 rtl/mem_master.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/mem_master_pkg.sv
// Shared definitions for the mem_master RAM initiator: FSM state encoding,
// request size / byte lane encodings and the lane-select helper.
package mem_master_pkg;

  localparam int MEM_WORDS_DEF = 2048;
  localparam int ADDR_W_DEF    = 16;

  localparam logic SIZE_BYTE = 1'b0;
  localparam logic SIZE_WORD = 1'b1;

  localparam logic LANE_LO = 1'b0;  // bits [7:0]
  localparam logic LANE_HI = 1'b1;  // bits [15:8]

  localparam logic [1:0] MEM_BE_FULL = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_RD     = 3'd1,
    ST_RDCAP  = 3'd2,
    ST_WR     = 3'd3,
    ST_RMW_RD = 3'd4,
    ST_RMW_WR = 3'd5,
    ST_RESP   = 3'd6
  } state_e;

  function automatic logic [7:0] lane_byte(input logic [15:0] word, input logic lane);
    return (lane == LANE_HI) ? word[15:8] : word[7:0];
  endfunction

endpackage

// File: rtl/mem_master_byte_lane.sv
// Combinational byte-lane helper for mem_master.
//   rd_word_i  in  16  word returned by the RAM
//   size_i     in   1  access size (byte/word)
//   lane_i     in   1  selected byte lane (byte address bit 0)
//   wr_byte_i  in   8  byte to insert for byte stores
//   rd_data_o  out 16  load result: whole word, or selected lane zero-extended
//   merge_o    out 16  RAM word with the selected lane replaced by wr_byte_i
module mem_master_byte_lane
  import mem_master_pkg::*;
(
  input  logic [15:0] rd_word_i,
  input  logic        size_i,
  input  logic        lane_i,
  input  logic [7:0]  wr_byte_i,
  output logic [15:0] rd_data_o,
  output logic [15:0] merge_o
);

  always_comb begin
    rd_data_o = rd_word_i;
    if (size_i == SIZE_BYTE) begin
      rd_data_o = {8'h00, lane_byte(rd_word_i, lane_i)};
    end

    merge_o = rd_word_i;
    if (lane_i == LANE_LO) begin
      merge_o[7:0] = wr_byte_i;
    end else begin
      merge_o[15:8] = wr_byte_i;
    end
  end

endmodule

// File: rtl/mem_master.sv
// Initiator for the 16-bit synchronous RAM port. Takes CPU load/store
// requests (byte or word, byte-addressed) over valid/ready, drives the RAM
// pins and returns a response held until accepted. Byte stores are done as
// read-modify-write so the other byte of the word is preserved.
//   clk, rst_n                  clock, async active-low reset
//   req_valid/req_ready         request handshake (ready only in IDLE)
//   req_we, req_size            store/load, byte/word
//   req_addr, req_wdata         byte address, store data (byte uses [7:0])
//   rsp_valid/rsp_ready         response handshake
//   rsp_rdata, rsp_err          load data (0 for stores/errors), error flag
//   mem_address, mem_data_in    RAM word address, RAM write data
//   mem_be, mem_we              byte enables (always full), write enable
//   mem_data_out                RAM read data, valid one cycle after address
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_IDLE   | waiting for a request, req_ready high
// ST_RD     | load: address on the RAM port
// ST_RDCAP  | load: RAM data valid, captured into the response
// ST_WR     | word store: mem_we high for this single cycle
// ST_RMW_RD | byte store: address on the RAM port to fetch the old word
// ST_RMW_WR | byte store: merged word written, mem_we high this cycle
// ST_RESP   | response presented until rsp_ready
module mem_master
  import mem_master_pkg::*;
#(
  parameter int MEM_WORDS = MEM_WORDS_DEF,
  parameter int ADDR_W    = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic              req_size,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [15:0]       req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [15:0]       rsp_rdata,
  output logic              rsp_err,
  output logic [ADDR_W-1:0] mem_address,
  output logic [15:0]       mem_data_in,
  output logic [1:0]        mem_be,
  output logic              mem_we,
  input  logic [15:0]       mem_data_out
);

  localparam logic [ADDR_W-1:0] MEM_WORDS_W = ADDR_W'(MEM_WORDS);

  state_e state_q, state_d;

  logic              size_q;
  logic              lane_q;
  logic [7:0]        wbyte_q;
  logic [ADDR_W-1:0] addr_q;
  logic [15:0]       data_in_q;
  logic [15:0]       rdata_q;
  logic              err_q;

  logic [ADDR_W-1:0] word_idx;
  logic              req_bad;
  logic              accept;
  logic [15:0]       lane_rdata;
  logic [15:0]       lane_merge;

  assign word_idx = {1'b0, req_addr[ADDR_W-1:1]};
  assign req_bad  = ((req_size == SIZE_WORD) && req_addr[0]) || (word_idx >= MEM_WORDS_W);
  assign accept   = req_valid && (state_q == ST_IDLE);

  mem_master_byte_lane u_byte_lane (
    .rd_word_i (mem_data_out),
    .size_i    (size_q),
    .lane_i    (lane_q),
    .wr_byte_i (wbyte_q),
    .rd_data_o (lane_rdata),
    .merge_o   (lane_merge)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          if (req_bad)                    state_d = ST_RESP;
          else if (!req_we)               state_d = ST_RD;
          else if (req_size == SIZE_WORD) state_d = ST_WR;
          else                            state_d = ST_RMW_RD;
        end
      end
      ST_RD:     state_d = ST_RDCAP;
      ST_RDCAP:  state_d = ST_RESP;
      ST_WR:     state_d = ST_RESP;
      ST_RMW_RD: state_d = ST_RMW_WR;
      ST_RMW_WR: state_d = ST_RESP;
      ST_RESP: begin
        if (rsp_ready) state_d = ST_IDLE;
      end
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Response registers are cleared at accept so stores and errors report 0;
  // a rejected request leaves the RAM-side address and data untouched.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      size_q    <= 1'b0;
      lane_q    <= 1'b0;
      wbyte_q   <= 8'h00;
      addr_q    <= '0;
      data_in_q <= 16'h0000;
      rdata_q   <= 16'h0000;
      err_q     <= 1'b0;
    end else begin
      if (accept) begin
        size_q  <= req_size;
        lane_q  <= req_addr[0];
        wbyte_q <= req_wdata[7:0];
        rdata_q <= 16'h0000;
        err_q   <= req_bad;
        if (!req_bad) begin
          addr_q <= word_idx;
          if (req_we) data_in_q <= req_wdata;
        end
      end
      if (state_q == ST_RDCAP) begin
        rdata_q <= lane_rdata;
      end
    end
  end

  // The RAM word arrives in ST_RMW_WR, so the merge is presented directly
  // from the RAM output in that cycle.
  assign mem_data_in = (state_q == ST_RMW_WR) ? lane_merge : data_in_q;
  assign mem_we      = (state_q == ST_WR) || (state_q == ST_RMW_WR);
  assign mem_address = addr_q;
  assign mem_be      = MEM_BE_FULL;
  assign req_ready   = (state_q == ST_IDLE);
  assign rsp_valid   = (state_q == ST_RESP);
  assign rsp_rdata   = rdata_q;
  assign rsp_err     = err_q;

endmodule
